instruction_fetch: RTL and testbench

IF-stage fetch unit for the 16-bit pipeline. It owns the IF/ID register (currentPC, instruction) that feeds the next-PC adder and the decoder. It consumes the adder's nextPC, fetches the instruction at that address over the shared instruction/data memory port with a req/ready handshake, and absorbs pipeline stalls, flushes and data-memory bus conflicts.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/fetch_hold_buf.sv | 29 ++
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: fetch FSM states, NOP encoding,
// reset vector and the jump-control codes used by the PC adder.
package cpu_pkg;

    localparam logic [15:0] NOP_ENCODING     = 16'h0800;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HELD  = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_REL  = 2'd1,
        JMP_ABS  = 2'd2,
        JMP_REG  = 2'd3
    } jump_ctrl_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Shared instruction/data memory port as seen by the fetch unit (master)
// and the memory/arbiter side (slave).
interface instruction_fetch_if;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_conflict;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready,
        input  mem_conflict
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ready,
        output mem_conflict
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry word buffer that parks a fetched instruction which arrived while
// the pipeline was stalled.
module fetch_hold_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            full <= 1'b0;
        end else begin
            if (load) begin
                dout <= din;
                full <= 1'b1;
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: fetches over the shared memory port with a req/ready handshake
// and owns the IF/ID register, absorbing stalls, flushes and bus conflicts.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [15:0] NOP_INSTR = NOP_ENCODING,
    parameter int          MAX_WAIT  = 8,
    parameter int          WCNT_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                nextPC,
    input  logic                       stall,
    input  logic                       flush,
    instruction_fetch_if.master        mem,
    output logic [15:0]                currentPC,
    output logic [15:0]                instruction,
    output logic                       valid,
    output logic                       fetch_err
);

    fetch_state_t      state, state_next;
    logic              first;
    logic              kill_pend;
    logic [15:0]       req_addr;
    logic [WCNT_W-1:0] wcnt;

    logic [15:0] fa;
    logic        kill;
    logic        req;
    logic [15:0] addr;
    logic        cap;
    logic [15:0] cap_addr;
    logic [15:0] cap_word;
    logic        issue_go;
    logic        buf_load;
    logic        buf_drain;
    logic [15:0] buf_word;
    logic        buf_full;

    assign fa   = first ? RESET_PC : nextPC;
    assign kill = kill_pend | flush;

    fetch_hold_buf #(.W(16)) u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .drain (buf_drain),
        .din   (mem.mem_rdata),
        .dout  (buf_word),
        .full  (buf_full)
    );

    always_comb begin
        state_next = state;
        req        = 1'b0;
        addr       = req_addr;
        cap        = 1'b0;
        cap_addr   = req_addr;
        cap_word   = mem.mem_rdata;
        issue_go   = 1'b0;
        buf_load   = 1'b0;
        buf_drain  = 1'b0;
        unique case (state)
            ISSUE: begin
                if (!stall && !mem.mem_conflict) begin
                    req      = 1'b1;
                    addr     = fa;
                    issue_go = 1'b1;
                    if (mem.mem_ready) begin
                        cap      = 1'b1;
                        cap_addr = fa;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            // The outstanding request keeps the bus, so conflicts are ignored here.
            WAIT: begin
                req = 1'b1;
                if (mem.mem_ready) begin
                    if (!stall) begin
                        cap        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = HELD;
                    end
                end
            end
            HELD: begin
                if (!stall && buf_full) begin
                    cap        = 1'b1;
                    cap_word   = buf_word;
                    buf_drain  = 1'b1;
                    state_next = ISSUE;
                end
            end
            default: state_next = ISSUE;
        endcase
    end

    // A dropped request during reset is tolerated by the memory side.
    assign mem.mem_req  = req & ~rst;
    assign mem.mem_addr = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ISSUE;
            first       <= 1'b1;
            kill_pend   <= 1'b0;
            req_addr    <= RESET_PC;
            wcnt        <= '0;
            currentPC   <= RESET_PC;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (issue_go) begin
                req_addr <= fa;
            end
            if (cap) begin
                currentPC   <= cap_addr;
                instruction <= kill ? NOP_INSTR : cap_word;
                valid       <= ~kill;
                kill_pend   <= 1'b0;
                first       <= 1'b0;
            end else if (flush) begin
                kill_pend <= 1'b1;
            end
            if (issue_go && !mem.mem_ready) begin
                wcnt <= WCNT_W'(1);
            end else if (state == WAIT && !mem.mem_ready) begin
                if (wcnt != '1) begin
                    wcnt <= wcnt + WCNT_W'(1);
                end
                if (wcnt >= WCNT_W'(MAX_WAIT - 1)) begin
                    fetch_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch plus hand-written
// sequences for wait states, stalls, flushes, timeout and mid-wait reset.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] nextPC;
    logic        stall;
    logic        flush;
    logic [15:0] currentPC;
    logic [15:0] instruction;
    logic        valid;
    logic        fetch_err;

    int n_checks;
    int n_fail;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .nextPC      (nextPC),
        .stall       (stall),
        .flush       (flush),
        .mem         (bus),
        .currentPC   (currentPC),
        .instruction (instruction),
        .valid       (valid),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        conflict;
        logic        ready;
        logic [15:0] rdata;
        logic [15:0] npc;
        logic        exp_req;
        logic        chk_addr;
        logic [15:0] exp_addr;
        logic [15:0] exp_pc;
        logic [15:0] exp_instr;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive at the falling edge, check the request combinationally, then the IF/ID state after the rising edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        stall            = v.stall;
        flush            = v.flush;
        bus.mem_conflict = v.conflict;
        bus.mem_ready    = v.ready;
        bus.mem_rdata    = v.rdata;
        nextPC           = v.npc;
        #1;
        checkOutput({tag, " mem_req"}, {15'd0, bus.mem_req}, {15'd0, v.exp_req});
        if (v.chk_addr) checkOutput({tag, " mem_addr"}, bus.mem_addr, v.exp_addr);
        @(posedge clk);
        #1;
        checkOutput({tag, " currentPC"}, currentPC, v.exp_pc);
        checkOutput({tag, " instruction"}, instruction, v.exp_instr);
        checkOutput({tag, " valid"}, {15'd0, valid}, {15'd0, v.exp_valid});
        checkOutput({tag, " fetch_err"}, {15'd0, fetch_err}, {15'd0, v.exp_err});
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " mem_req"}, {15'd0, bus.mem_req}, 16'd0);
        checkOutput({tag, " currentPC"}, currentPC, 16'h0000);
        checkOutput({tag, " instruction"}, instruction, 16'h0800);
        checkOutput({tag, " valid"}, {15'd0, valid}, 16'd0);
        checkOutput({tag, " fetch_err"}, {15'd0, fetch_err}, 16'd0);
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        stall            = 1'b0;
        flush            = 1'b0;
        nextPC           = 16'h1234;
        bus.mem_conflict = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.mem_rdata    = 16'h0000;

        //         stall flush conf rdy  rdata     npc       req  chka addr      pc        instr     vld  err
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h1234, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h1111, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 16'h0002, 1'b1, 1'b1, 16'h0002, 16'h0002, 16'h2222, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h3333, 16'h0004, 1'b1, 1'b1, 16'h0004, 16'h0004, 16'h3333, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hBAD0, 16'h0006, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h3333, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hBAD1, 16'h0006, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h3333, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4444, 16'h0006, 1'b1, 1'b1, 16'h0006, 16'h0006, 16'h4444, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hBAD2, 16'h0008, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'h4444, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h5555, 16'h0008, 1'b1, 1'b1, 16'h0008, 16'h0008, 16'h0800, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h6666, 16'h000A, 1'b1, 1'b1, 16'h000A, 16'h000A, 16'h6666, 1'b1, 1'b0};

        #12;
        checkReset("reset");
        stall = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] zero-wait stream, conflict, stall, flush");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        $display("[TB] three-cycle ready delay at 0x0010");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 1'b1, 1'b1, 16'h0010, 16'h000A, 16'h6666, 1'b1, 1'b0}, "dly0");
        applyStimulus('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 1'b1, 1'b1, 16'h0010, 16'h000A, 16'h6666, 1'b1, 1'b0}, "dly1");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0030, 1'b1, 1'b1, 16'h0010, 16'h000A, 16'h6666, 1'b1, 1'b0}, "dly2");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h0040, 1'b1, 1'b1, 16'h0010, 16'h0010, 16'h7777, 1'b1, 1'b0}, "dly3");

        $display("[TB] stall while ready arrives");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0012, 1'b1, 1'b1, 16'h0012, 16'h0010, 16'h7777, 1'b1, 1'b0}, "hold0");
        applyStimulus('{1'b1, 1'b0, 1'b0, 1'b1, 16'h4A05, 16'h0012, 1'b1, 1'b1, 16'h0012, 16'h0010, 16'h7777, 1'b1, 1'b0}, "hold1");
        applyStimulus('{1'b1, 1'b0, 1'b0, 1'b0, 16'hBAD3, 16'h0012, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h7777, 1'b1, 1'b0}, "hold2");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b1, 16'hDEAD, 16'h0012, 1'b0, 1'b0, 16'h0000, 16'h0012, 16'h4A05, 1'b1, 1'b0}, "hold3");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b1, 16'h1414, 16'h0014, 1'b1, 1'b1, 16'h0014, 16'h0014, 16'h1414, 1'b1, 1'b0}, "hold4");

        $display("[TB] flush during outstanding fetch");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0016, 1'b1, 1'b1, 16'h0016, 16'h0014, 16'h1414, 1'b1, 1'b0}, "fl0");
        applyStimulus('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0016, 1'b1, 1'b1, 16'h0016, 16'h0014, 16'h1414, 1'b1, 1'b0}, "fl1");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b1, 16'h9999, 16'h0016, 1'b1, 1'b1, 16'h0016, 16'h0016, 16'h0800, 1'b0, 1'b0}, "fl2");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b1, 16'h1818, 16'h0018, 1'b1, 1'b1, 16'h0018, 16'h0018, 16'h1818, 1'b1, 1'b0}, "fl3");

        $display("[TB] memory timeout then reset mid-wait");
        for (int i = 0; i < 10; i++) begin
            v = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h001A, 1'b1, 1'b1, 16'h001A,
                  16'h0018, 16'h1818, 1'b1, (i >= 7)};
            applyStimulus(v, $sformatf("tmo%0d", i));
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkReset("midrst");
        stall = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h0050, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hABCD, 1'b1, 1'b0}, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
